aes128_sbox: RTL and testbench

Dual-port 256x8 lookup memory pre-loaded with the AES forward S-box (FIPS-197 SubBytes table). It serves byte substitution for the 128-bit AES core with a 3-cycle round; four instances provide eight lookups per cycle. Both ports read independently and synchronously, and both are writable so the table can be patched at run time.

---
 rtl/aes128_sbox_if.sv | 26 ++
 rtl/aes128_sbox.sv | 86 ++++++++
 tb/tb_aes128_sbox.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_sbox_if.sv
// Port bundle for the dual-port AES S-box table: two independent read/write ports.
interface aes128_sbox_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              wea;
    logic              web;
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dia;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] doa;
    logic [DATA_W-1:0] dob;

    // Requester side: drives addresses/writes, consumes read data.
    modport master (
        output wea, web, addra, addrb, dia, dib,
        input  doa, dob
    );

    // Table side.
    modport slave (
        input  wea, web, addra, addrb, dia, dib,
        output doa, dob
    );
endinterface

// File: rtl/aes128_sbox.sv
// Dual-port 256x8 table pre-loaded with the AES forward S-box. Both ports read
// synchronously every cycle (read-first) and can patch entries at run time.
// rst only clears the output registers; table contents survive reset.
module aes128_sbox #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    aes128_sbox_if.slave bus
);
    localparam int unsigned Depth = 1 << ADDR_W;

    // Power-on image is the FIPS-197 SubBytes table, row n holds entries 16n..16n+15.
    logic [DATA_W-1:0] mem_q [Depth] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [DATA_W-1:0] doa_d, doa_q;
    logic [DATA_W-1:0] dob_d, dob_q;
    logic              b_write;

    // Port A owns a shared address when both ports write it in the same cycle.
    assign b_write = bus.web && !(bus.wea && (bus.addra == bus.addrb));

    // Table update: independent of rst so writes land even while outputs are held.
    always_ff @(posedge clk) begin
        if (b_write) begin
            mem_q[bus.addrb] <= bus.dib;
        end
        if (bus.wea) begin
            mem_q[bus.addra] <= bus.dia;
        end
    end

    // Read-first lookup: sample old contents before this edge's writes commit.
    always_comb begin
        doa_d = mem_q[bus.addra];
        dob_d = mem_q[bus.addrb];
    end

    // Output registers; async reset forces zero immediately and holds while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            doa_q <= '0;
            dob_q <= '0;
        end else begin
            doa_q <= doa_d;
            dob_q <= dob_d;
        end
    end

    assign bus.doa = doa_q;
    assign bus.dob = dob_q;
endmodule

// File: tb/tb_aes128_sbox.sv
// Self-checking bench for aes128_sbox: reference S-box computed from GF(2^8)
// arithmetic, a shadow memory model, and per-port expected-value queues.
module tb_aes128_sbox;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_sbox_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    aes128_sbox #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [256];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // One clock of stimulus: push read-first expectations, then update the shadow memory.
    task automatic drive(input logic wa, input logic wb, input logic [7:0] aa,
                         input logic [7:0] ab, input logic [7:0] da, input logic [7:0] db);
        bus.wea   = wa;
        bus.web   = wb;
        bus.addra = aa;
        bus.addrb = ab;
        bus.dia   = da;
        bus.dib   = db;
        exp_a.push_back(model[aa]);
        exp_b.push_back(model[ab]);
        @(posedge clk);
        if (wb && !(wa && aa == ab)) model[ab] = db;
        if (wa) model[aa] = da;
        #1;
        bus.wea = 1'b0;
        bus.web = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] ea, eb;
        rst       = 1'b1;
        bus.addra = 8'h53;
        bus.addrb = 8'h53;
        #1;
        checks++;
        if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
            failures++;
            $display("FAIL reset_async doa=%02h dob=%02h expected 00/00", bus.doa, bus.dob);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold doa=%02h dob=%02h expected 00/00", bus.doa, bus.dob);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h53, 8'h53, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.doa !== 8'hed) begin
            failures++;
            $display("FAIL reset_release_a doa=%02h expected %02h", bus.doa, ea);
        end
        checks++;
        if (bus.dob !== eb || bus.dob !== 8'hed) begin
            failures++;
            $display("FAIL reset_release_b dob=%02h expected %02h", bus.dob, eb);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] ea, eb, addr;
        addr = 8'h00;
        for (int i = 0; i < 257; i++) begin
            drive(1'b0, 1'b0, addr, addr, 8'h00, 8'h00);
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            checks++;
            if (bus.doa !== ea || bus.dob !== eb) begin
                failures++;
                $display("FAIL sweep addr=%02h doa=%02h dob=%02h expected %02h/%02h",
                         addr, bus.doa, bus.dob, ea, eb);
            end
            addr = addr + 8'h01;
        end
        checks++;
        if (bus.doa !== 8'h63) begin
            failures++;
            $display("FAIL sweep_wrap doa=%02h expected 63", bus.doa);
        end
    endtask

    task automatic test_ports();
        logic [7:0] ea, eb;
        drive(1'b0, 1'b0, 8'h10, 8'h80, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.doa !== 8'hca) begin
            failures++;
            $display("FAIL ports_a doa=%02h expected %02h", bus.doa, ea);
        end
        checks++;
        if (bus.dob !== eb || bus.dob !== 8'hcd) begin
            failures++;
            $display("FAIL ports_b dob=%02h expected %02h", bus.dob, eb);
        end
    endtask

    task automatic test_write();
        logic [7:0] ea, eb;
        drive(1'b1, 1'b0, 8'h00, 8'hff, 8'haa, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.doa !== 8'h63) begin
            failures++;
            $display("FAIL write_read_first doa=%02h expected %02h", bus.doa, ea);
        end
        checks++;
        if (bus.dob !== eb) begin
            failures++;
            $display("FAIL write_other_port dob=%02h expected %02h", bus.dob, eb);
        end
        drive(1'b0, 1'b0, 8'h07, 8'h00, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.dob !== eb || bus.dob !== 8'haa) begin
            failures++;
            $display("FAIL write_visible_b dob=%02h expected %02h", bus.dob, eb);
        end
        checks++;
        if (bus.doa !== ea) begin
            failures++;
            $display("FAIL write_neighbour_a doa=%02h expected %02h", bus.doa, ea);
        end
    endtask

    task automatic test_collision();
        logic [7:0] ea, eb;
        drive(1'b1, 1'b1, 8'h01, 8'h01, 8'h11, 8'h22);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.dob !== eb) begin
            failures++;
            $display("FAIL collide_old doa=%02h dob=%02h expected %02h/%02h",
                     bus.doa, bus.dob, ea, eb);
        end
        // Port A writes 0x02 while port B reads it: B must see the old entry.
        drive(1'b1, 1'b0, 8'h02, 8'h02, 8'h55, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.dob !== eb || bus.dob !== 8'h77) begin
            failures++;
            $display("FAIL cross_read_first dob=%02h expected %02h", bus.dob, eb);
        end
        drive(1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.dob !== eb || bus.doa !== 8'h11) begin
            failures++;
            $display("FAIL collide_a_wins doa=%02h dob=%02h expected %02h/%02h",
                     bus.doa, bus.dob, ea, eb);
        end
        drive(1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== ea || bus.dob !== eb) begin
            failures++;
            $display("FAIL cross_write_visible doa=%02h dob=%02h expected %02h/%02h",
                     bus.doa, bus.dob, ea, eb);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] ea, eb, addr;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'(8'h30 + i), 8'(8'hc0 + i), 8'h00, 8'h00);
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            checks++;
            if (bus.doa !== ea || bus.dob !== eb) begin
                failures++;
                $display("FAIL pre_reset_sweep doa=%02h dob=%02h expected %02h/%02h",
                         bus.doa, bus.dob, ea, eb);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
            failures++;
            $display("FAIL midcycle_reset doa=%02h dob=%02h expected 00/00", bus.doa, bus.dob);
        end
        // A write issued while rst is high must still reach the table.
        bus.wea   = 1'b1;
        bus.addra = 8'h40;
        bus.dia   = 8'h99;
        bus.addrb = 8'h41;
        @(posedge clk);
        model[8'h40] = 8'h99;
        #1;
        bus.wea = 1'b0;
        checks++;
        if (bus.doa !== 8'h00 || bus.dob !== 8'h00) begin
            failures++;
            $display("FAIL reset_edge_hold doa=%02h dob=%02h expected 00/00", bus.doa, bus.dob);
        end
        #2;
        rst = 1'b0;
        addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, addr, 8'(addr + 8'h3e), 8'h00, 8'h00);
            ea = exp_a.pop_front();
            eb = exp_b.pop_front();
            checks++;
            if (bus.doa !== ea || bus.dob !== eb) begin
                failures++;
                $display("FAIL resume_sweep addr=%02h doa=%02h dob=%02h expected %02h/%02h",
                         addr, bus.doa, bus.dob, ea, eb);
            end
            addr = addr + 8'h01;
        end
        drive(1'b0, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00);
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks++;
        if (bus.doa !== 8'haa || bus.dob !== 8'h99) begin
            failures++;
            $display("FAIL retained doa=%02h dob=%02h expected aa/99", bus.doa, bus.dob);
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.wea   = 1'b0;
        bus.web   = 1'b0;
        bus.addra = 8'h00;
        bus.addrb = 8'h00;
        bus.dia   = 8'h00;
        bus.dib   = 8'h00;
        for (int i = 0; i < 256; i++) model[i] = sbox_calc(8'(i));
        test_reset();
        test_sweep();
        test_ports();
        test_write();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
